// File: rtl/knn_threshold_filter.sv
// knn_threshold_filter: per-lane threshold filter for KNN candidate batches.
// Each accepted batch has every lane's valid bit ANDed with a distance
// compare against a running-mean threshold, then the batch and its popcount
// are queued in a small FIFO for the downstream consumer. A saturating
// counter accumulates the number of lanes that survived the filter.

`ifndef B
`define B 16
`endif

package knn_pkg;
  localparam int DIST_W = `B;

  typedef struct packed {
    logic              valid;
    logic [DIST_W-1:0] distance;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
    logic [15:0]       point_id;
  } knn_entry_t;
endpackage

module knn_threshold_filter
  import knn_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DEPTH  = 4,
  parameter int STRICT = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         thr_load,
  input  logic [DIST_W-1:0]            thr_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  knn_entry_t [LANES-1:0]       in_entries,
  output logic                         out_valid,
  input  logic                         out_ready,
  output knn_entry_t [LANES-1:0]       out_entries,
  output logic [$clog2(LANES+1)-1:0]   out_taken_cnt,
  input  logic                         stat_clear,
  output logic [31:0]                  kept_total
);

  localparam int CNT_W = $clog2(LANES+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  // Lane passes when its distance is within the threshold (inclusive unless STRICT).
  function automatic logic dist_pass(input logic [DIST_W-1:0] d, input logic [DIST_W-1:0] t);
    if (STRICT != 0) return d < t;
    else             return d <= t;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input knn_entry_t [LANES-1:0] b);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int l = 0; l < LANES; l++) s = s + CNT_W'(b[l].valid);
    return s;
  endfunction

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CNT_W-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [DIST_W-1:0]       thr_q;
  knn_entry_t [LANES-1:0]  filt_p0;
  logic [CNT_W-1:0]        taken_p0;

  knn_entry_t [LANES-1:0]  mem_p1 [DEPTH];
  logic [CNT_W-1:0]        cnt_mem_p1 [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [OCC_W-1:0]        occ_q;
  logic                    vld_p1;
  logic [31:0]             kept_q;

  logic push;
  logic pop;

  // ---- stage p0: combinational filter of the incoming batch ----
  // Apply the threshold compare to each lane; payload fields pass untouched.
  always_comb begin
    filt_p0 = in_entries;
    for (int l = 0; l < LANES; l++) begin
      filt_p0[l].valid = in_entries[l].valid && dist_pass(in_entries[l].distance, thr_q);
    end
    taken_p0 = popcount(filt_p0);
  end

  assign in_ready = (occ_q < OCC_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = vld_p1 && out_ready;

  // Threshold register; a load only affects batches accepted on later edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      thr_q <= '1;
    else if (thr_load) thr_q <= thr_in;
  end

  // ---- stage p1: FIFO storage (data, not reset) ----
  // Write the filtered batch and its popcount at the write pointer.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_p1[wr_ptr_q]     <= filt_p0;
      cnt_mem_p1[wr_ptr_q] <= taken_p0;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign vld_p1        = (occ_q != '0);
  assign out_valid     = vld_p1;
  assign out_entries   = mem_p1[rd_ptr_q];
  assign out_taken_cnt = cnt_mem_p1[rd_ptr_q];

  // Saturating kept-lane counter; a clear that coincides with an acceptance
  // restarts the count at that batch's popcount.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kept_q <= '0;
    end else if (push) begin
      kept_q <= stat_clear ? 32'(taken_p0) : sat_add(kept_q, taken_p0);
    end else if (stat_clear) begin
      kept_q <= '0;
    end
  end

  assign kept_total = kept_q;

endmodule

// File: tb/tb_knn_threshold_filter.sv
// Directed bench for knn_threshold_filter: a STRICT=0 and a STRICT=1 instance
// share one stimulus stream; a vector table covers the filter function and
// hand-written sequences cover backpressure, saturation and reset.
module tb_knn_threshold_filter;
  import knn_pkg::*;

  localparam int L = 4;
  localparam int D = 4;

  typedef knn_entry_t [L-1:0]        batch_t;
  typedef logic [L-1:0][DIST_W-1:0]  dvec_t;

  typedef struct {
    logic              ld;
    logic [DIST_W-1:0] thr;
    dvec_t             d;
    logic [L-1:0]      vin;
    logic [L-1:0]      e0;
    logic [L-1:0]      e1;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              thr_load;
  logic [DIST_W-1:0] thr_in;
  logic              in_valid;
  logic              out_ready;
  logic              stat_clear;
  batch_t            in_entries;
  batch_t            out_e0, out_e1;
  logic              in_ready0, in_ready1, out_valid0, out_valid1;
  logic [2:0]        cnt0, cnt1;
  logic [31:0]       kt0, kt1;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] kexp;
  vec_t        vecs [9];

  always #5 clock = ~clock;

  knn_threshold_filter #(.LANES(L), .DEPTH(D), .STRICT(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .thr_load(thr_load), .thr_in(thr_in),
    .in_valid(in_valid), .in_ready(in_ready0), .in_entries(in_entries),
    .out_valid(out_valid0), .out_ready(out_ready), .out_entries(out_e0),
    .out_taken_cnt(cnt0), .stat_clear(stat_clear), .kept_total(kt0));

  knn_threshold_filter #(.LANES(L), .DEPTH(D), .STRICT(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .thr_load(thr_load), .thr_in(thr_in),
    .in_valid(in_valid), .in_ready(in_ready1), .in_entries(in_entries),
    .out_valid(out_valid1), .out_ready(out_ready), .out_entries(out_e1),
    .out_taken_cnt(cnt1), .stat_clear(stat_clear), .kept_total(kt1));

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic batch_t mk(input dvec_t d, input logic [L-1:0] v, input logic [15:0] pid);
    batch_t e;
    for (int l = 0; l < L; l++) begin
      e[l].valid    = v[l];
      e[l].distance = d[l];
      e[l].x        = 16'(-(l + 1) * 7);
      e[l].y        = 16'(l * 1000 + int'(pid));
      e[l].z        = 16'(int'(pid) * 3 - l);
      e[l].point_id = pid + 16'(l);
    end
    return e;
  endfunction

  function automatic dvec_t same_d(input logic [DIST_W-1:0] v);
    dvec_t d;
    for (int l = 0; l < L; l++) d[l] = v;
    return d;
  endfunction

  initial begin
    dvec_t d_a;
    d_a = {16'd50, 16'd101, 16'd100, 16'd99};
    //            ld    thr           d                                         vin      e0       e1
    vecs[0] = '{1'b1, 16'd100,    d_a,                                        4'b1111, 4'b1111, 4'b1111};
    vecs[1] = '{1'b0, 16'd0,      d_a,                                        4'b1111, 4'b1011, 4'b1001};
    vecs[2] = '{1'b0, 16'd0,      d_a,                                        4'b0101, 4'b0001, 4'b0001};
    vecs[3] = '{1'b1, 16'd10,     same_d(16'd50),                             4'b1111, 4'b1111, 4'b1111};
    vecs[4] = '{1'b0, 16'd0,      same_d(16'd50),                             4'b1111, 4'b0000, 4'b0000};
    vecs[5] = '{1'b1, 16'd0,      {16'd0, 16'd11, 16'd9, 16'd10},             4'b1111, 4'b1011, 4'b1010};
    vecs[6] = '{1'b1, 16'hFFFF,   {16'd1, 16'd0, 16'd0, 16'd0},               4'b1111, 4'b0111, 4'b0000};
    vecs[7] = '{1'b0, 16'd0,      {16'd1, 16'd0, 16'hFFFE, 16'hFFFF},         4'b1111, 4'b1111, 4'b1110};
    vecs[8] = '{1'b0, 16'd0,      same_d(16'd0),                              4'b0000, 4'b0000, 4'b0000};

    reset_n = 1'b0; thr_load = 1'b0; thr_in = '0; in_valid = 1'b0;
    out_ready = 1'b0; stat_clear = 1'b0; in_entries = '0;
    kexp = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 512'(out_valid0), 512'(1'b0));
    chk("rst_kept", 512'(kt0), 512'(32'd0));
    @(negedge clock); reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 512'(in_ready0), 512'(1'b1));

    // Table-driven filter vectors, one accepted batch per cycle.
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      thr_load   = vecs[i].ld;
      thr_in     = vecs[i].thr;
      in_entries = mk(vecs[i].d, vecs[i].vin, 16'(i * 16));
      in_valid   = 1'b1;
      out_ready  = 1'b1;
      @(posedge clock); #1;
      thr_load = 1'b0;
      in_valid = 1'b0;
      kexp = kexp + 32'($countones(vecs[i].e0));
      chk($sformatf("v%0d_out_valid", i), 512'(out_valid0 & out_valid1), 512'(1'b1));
      chk($sformatf("v%0d_entries_s0", i), 512'(out_e0), 512'(mk(vecs[i].d, vecs[i].e0, 16'(i * 16))));
      chk($sformatf("v%0d_entries_s1", i), 512'(out_e1), 512'(mk(vecs[i].d, vecs[i].e1, 16'(i * 16))));
      chk($sformatf("v%0d_cnt_s0", i), 512'(cnt0), 512'($countones(vecs[i].e0)));
      chk($sformatf("v%0d_cnt_s1", i), 512'(cnt1), 512'($countones(vecs[i].e1)));
      chk($sformatf("v%0d_kept", i), 512'(kt0), 512'(kexp));
    end
    @(posedge clock); #1;
    chk("drain_out_valid", 512'(out_valid0), 512'(1'b0));

    // Backpressure: fill the FIFO with out_ready low (threshold is now 0xFFFF).
    for (int k = 0; k < D; k++) begin
      @(negedge clock);
      out_ready  = 1'b0;
      in_entries = mk(same_d(16'(k + 1)), 4'b1111, 16'(16'h100 + k * 16));
      in_valid   = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      kexp = kexp + 32'd4;
      chk($sformatf("bp_in_ready_%0d", k), 512'(in_ready0), 512'(k < D - 1));
    end
    chk("bp_in_ready_s1", 512'(in_ready1), 512'(1'b0));
    chk("bp_head0", 512'(out_e0), 512'(mk(same_d(16'd1), 4'b1111, 16'h100)));
    // Offer a fifth batch while full and stalled.
    @(negedge clock);
    in_entries = mk(same_d(16'd7), 4'b1111, 16'h200);
    in_valid   = 1'b1;
    @(posedge clock); #1;
    chk("bp_hold_head", 512'(out_e0), 512'(mk(same_d(16'd1), 4'b1111, 16'h100)));
    chk("bp_hold_cnt", 512'(cnt0), 512'(3'd4));
    // Pop while full with the fifth batch still offered: it must not enter.
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int k = 1; k < D; k++) begin
      chk($sformatf("bp_order_%0d", k), 512'({out_valid0, out_e0}),
          512'({1'b1, mk(same_d(16'(k + 1)), 4'b1111, 16'(16'h100 + k * 16))}));
      @(posedge clock); #1;
    end
    chk("bp_no_extra", 512'(out_valid0), 512'(1'b0));
    chk("bp_kept", 512'(kt0), 512'(kexp));

    // Saturation of kept_total, then clear coinciding with acceptance.
    @(negedge clock);
    force dut0.kept_q = 32'hFFFF_FFFE;
    #1;
    release dut0.kept_q;
    chk("sat_preset", 512'(kt0), 512'(32'hFFFF_FFFE));
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      in_entries = mk(same_d(16'd5), 4'b1111, 16'h300);
      in_valid   = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk($sformatf("sat_kept_%0d", k), 512'(kt0), 512'(32'hFFFF_FFFF));
    end
    @(negedge clock);
    stat_clear = 1'b1;
    in_entries = mk(same_d(16'd5), 4'b0011, 16'h310);
    in_valid   = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("clr_push_kept_s0", 512'(kt0), 512'(32'd2));
    chk("clr_push_kept_s1", 512'(kt1), 512'(32'd2));
    @(posedge clock); #1;
    stat_clear = 1'b0;
    chk("clr_only_kept", 512'(kt0), 512'(32'd0));

    // Reset with batches buffered.
    @(negedge clock);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_entries = mk(same_d(16'd3), 4'b1111, 16'(16'h400 + k * 16));
      in_valid   = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    chk("mid_buffered", 512'({out_valid0, kt0}), 512'({1'b1, 32'd12}));
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 512'(out_valid0), 512'(1'b0));
    chk("mid_rst_kept", 512'(kt0), 512'(32'd0));
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_idle", 512'({out_valid0, in_ready0}), 512'(2'b01));
    @(negedge clock);
    in_entries = mk(same_d(16'hFFFF), 4'b1111, 16'h500);
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("post_rst_all_ones_s0", 512'(out_e0), 512'(mk(same_d(16'hFFFF), 4'b1111, 16'h500)));
    chk("post_rst_all_ones_s1", 512'(out_e1), 512'(mk(same_d(16'hFFFF), 4'b0000, 16'h500)));
    chk("post_rst_cnt", 512'(cnt0), 512'(3'd4));
    @(posedge clock); #1;
    chk("post_rst_no_stale", 512'(out_valid0), 512'(1'b0));
    chk("post_rst_kept", 512'(kt0), 512'(32'd4));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/knn_threshold_filter.md
KNN_THRESHOLD_FILTER -- requirements
Module: knn_threshold_filter

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning knn_entry_t candidates per batch (1..16).
REQ-002 SHALL have parameter DEPTH, default 4, meaning output FIFO depth in batches (power of two, 2..16).
REQ-003 SHALL have parameter STRICT, default 0, meaning 0 selects distance <= threshold and 1 selects distance < threshold.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port thr_load, input, 1, which loads thr_in into the threshold register.
REQ-007 SHALL have port thr_in, input, `B, the new running-mean threshold.
REQ-008 SHALL have port in_valid, input, 1, meaning the batch on in_entries is presented.
REQ-009 SHALL have port in_ready, output, 1, meaning a batch can be accepted this cycle.
REQ-010 SHALL have port in_entries, input, LANES x knn_entry_t, the candidate batch.
REQ-011 SHALL have port out_valid, output, 1, meaning the FIFO head batch is presented.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer takes the head batch.
REQ-013 SHALL have port out_entries, output, LANES x knn_entry_t, the filtered batch.
REQ-014 SHALL have port out_taken_cnt, output, $clog2(LANES+1), the number of valid lanes in the head batch.
REQ-015 SHALL have port stat_clear, input, 1, which synchronously clears kept_total.
REQ-016 SHALL have port kept_total, output, 32, a saturating count of all lanes passed valid.

Function
REQ-017 SHALL accept a batch on any cycle where in_valid and in_ready are both 1.
REQ-018 SHALL drive in_ready = 1 when FIFO occupancy < DEPTH, with no push on the cycle the FIFO is full even if a pop occurs.
REQ-019 SHALL, per lane of an accepted batch, set out valid = in valid AND (distance <= thr for STRICT=0, or distance < thr for STRICT=1), as an unsigned `B-bit compare.
REQ-020 SHALL pass distance, x, y, z and point_id of every lane through unchanged, including lanes marked invalid.
REQ-021 SHALL compare against the threshold register value held before the edge; thr_load in the same cycle as acceptance affects only later batches.
REQ-022 SHALL write the filtered batch and its popcount into the FIFO on acceptance.
REQ-023 SHALL present a batch accepted in cycle N at the output in cycle N+1 when the FIFO was empty; there SHALL be no combinational in-to-out path.
REQ-024 SHALL pop the head when out_valid and out_ready are both 1; out_entries and out_taken_cnt SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 SHALL handle a simultaneous push and pop with FIFO not full by leaving occupancy unchanged; read and write pointers wrap modulo DEPTH.
REQ-026 SHALL add the accepted batch's popcount to kept_total on acceptance, saturating at 0xFFFFFFFF.
REQ-027 SHALL, when stat_clear and an acceptance coincide, set kept_total to that batch's popcount.
REQ-028 SHALL ignore in_entries whenever in_valid=0; out_entries SHALL be don't-care whenever out_valid=0.

Reset
REQ-029 SHALL, on reset_n low, asynchronously set FIFO occupancy and pointers 0, out_valid 0, in_ready 1 after release, threshold register all-ones, and kept_total 0.
REQ-030 SHALL discard all buffered batches when reset is asserted mid-operation; no batch SHALL emerge after release unless newly accepted.

Verification
REQ-031 SHALL cover: STRICT=0, thr=100, LANES=4 batch with distances 99/100/101/50, all valid -> next cycle out valid bits 1/1/0/1, out_taken_cnt=3, kept_total=3.
REQ-032 SHALL cover: STRICT=1 with the same stimulus -> valid bits 1/0/0/1, out_taken_cnt=2.
REQ-033 SHALL cover: thr_load thr_in=10 in the same cycle as a batch with distance 50 and old thr=100 -> that lane valid; the next batch with distance 50 -> invalid.
REQ-034 SHALL cover: out_ready=0 while pushing DEPTH batches -> in_ready drops after the DEPTH-th acceptance; with out_ready=1, batches emerge in order with no loss or duplication.
REQ-035 SHALL cover: kept_total preset near saturation (0xFFFFFFFE) plus a batch with 4 taken -> 0xFFFFFFFF; stat_clear with a concurrent 2-taken batch -> 2.
REQ-036 SHALL cover: reset_n pulsed low with 3 batches buffered -> out_valid=0 immediately, kept_total=0, and a batch with all distances 0xFFFF..F passes all-valid after release due to the all-ones threshold.
